// File: rtl/text_pkg.sv
// Shared dimensions for the text-mode glyph path: font ROM geometry and attribute layout.
package text_pkg;

    localparam int unsigned CHAR_W        = 8;
    localparam int unsigned ROW_W         = 4;
    localparam int unsigned GLYPH_W       = 8;
    localparam int unsigned COLOR_W       = 4;
    localparam int unsigned FONT_ADDR_W   = CHAR_W + ROW_W;
    localparam int unsigned ATTR_W        = 2 * COLOR_W;
    localparam int unsigned FG_MSB        = 2 * COLOR_W - 1;
    localparam int unsigned FG_LSB        = COLOR_W;
    localparam int unsigned BG_MSB        = COLOR_W - 1;
    localparam int unsigned BG_LSB        = 0;
    localparam int unsigned PIX_PER_GLYPH = 8;

endpackage

// File: rtl/glyph_pixel_serializer_glyph_shifter.sv
// Glyph row shift register: emits one coloured pixel per handshake, MSB first.
module glyph_shifter #(
    parameter int unsigned GLYPH_W = text_pkg::GLYPH_W,
    parameter int unsigned COLOR_W = text_pkg::COLOR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   load,
    input  logic [GLYPH_W-1:0]     load_data,
    input  logic [2*COLOR_W-1:0]   load_attr,
    input  logic                   pix_ready,
    output logic                   pix_valid,
    output logic [COLOR_W-1:0]     pix_color,
    output logic                   pix_last,
    output logic                   empty,
    output logic                   last_fire
);

    localparam int unsigned CNT_W = $clog2(GLYPH_W + 1);

    logic [GLYPH_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*COLOR_W-1:0] attr_q, attr_d;
    logic                 fire;

    assign pix_valid = (cnt_q != '0);
    assign pix_last  = (cnt_q == CNT_W'(1));
    assign pix_color = sh_q[GLYPH_W-1] ? attr_q[2*COLOR_W-1:COLOR_W] : attr_q[COLOR_W-1:0];
    assign empty     = (cnt_q == '0);
    assign fire      = pix_valid && pix_ready;
    assign last_fire = fire && pix_last;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        attr_d = attr_q;
        if (flush) begin
            sh_d   = '0;
            cnt_d  = '0;
            attr_d = '0;
        end else if (load) begin
            // A load on the final handshake replaces the shift, so the next glyph follows with no gap.
            sh_d   = load_data;
            cnt_d  = CNT_W'(GLYPH_W);
            attr_d = load_attr;
        end else if (fire) begin
            sh_d  = {sh_q[GLYPH_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            attr_q <= '0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            attr_q <= attr_d;
        end
    end

endmodule

// File: rtl/glyph_pixel_serializer.sv
// Font ROM initiator: accepts glyph requests, issues the ROM read, stages the returned row and serializes it.
module glyph_pixel_serializer #(
    parameter int unsigned CHAR_W  = text_pkg::CHAR_W,
    parameter int unsigned ROW_W   = text_pkg::ROW_W,
    parameter int unsigned GLYPH_W = text_pkg::GLYPH_W,
    parameter int unsigned COLOR_W = text_pkg::COLOR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      char_valid,
    output logic                      char_ready,
    input  logic [CHAR_W-1:0]         char_code,
    input  logic [ROW_W-1:0]          char_row,
    input  logic [2*COLOR_W-1:0]      char_attr,
    output logic                      font_en,
    output logic [CHAR_W+ROW_W-1:0]   font_addr,
    input  logic [GLYPH_W-1:0]        font_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [COLOR_W-1:0]        pix_color,
    output logic                      pix_last
);

    localparam int unsigned ADDR_W = CHAR_W + ROW_W;
    localparam int unsigned ATTR_W = 2 * COLOR_W;

    logic                ready_q, ready_d;
    logic                font_en_q, font_en_d;
    logic [ADDR_W-1:0]   font_addr_q, font_addr_d;
    logic [ATTR_W-1:0]   req_attr_q, req_attr_d;
    logic                rdata_vld_q, rdata_vld_d;
    logic                stg_full_q, stg_full_d;
    logic [GLYPH_W-1:0]  stg_glyph_q, stg_glyph_d;
    logic [ATTR_W-1:0]   stg_attr_q, stg_attr_d;

    logic                accept;
    logic                load;
    logic [GLYPH_W-1:0]  load_glyph;
    logic [ATTR_W-1:0]   load_attr;
    logic                sh_empty;
    logic                sh_last_fire;

    assign char_ready = ready_q && !flush;
    assign accept     = char_valid && char_ready;
    assign font_en    = font_en_q;
    assign font_addr  = font_addr_q;

    always_comb begin
        // Returning ROM data bypasses staging straight into an idle shifter to hit 3-cycle latency.
        load_glyph  = stg_full_q ? stg_glyph_q : font_data;
        load_attr   = stg_full_q ? stg_attr_q  : req_attr_q;
        load        = (stg_full_q || rdata_vld_q) && (sh_empty || sh_last_fire) && !flush;

        font_en_d   = accept;
        font_addr_d = accept ? {char_code, char_row} : font_addr_q;
        req_attr_d  = accept ? char_attr : req_attr_q;
        rdata_vld_d = font_en_q && !flush;

        stg_full_d  = stg_full_q;
        stg_glyph_d = stg_glyph_q;
        stg_attr_d  = stg_attr_q;
        if (flush || load) begin
            stg_full_d = 1'b0;
        end else if (rdata_vld_q) begin
            stg_full_d  = 1'b1;
            stg_glyph_d = font_data;
            stg_attr_d  = req_attr_q;
        end

        ready_d = !stg_full_d && !font_en_d && !rdata_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            font_en_q   <= 1'b0;
            font_addr_q <= '0;
            req_attr_q  <= '0;
            rdata_vld_q <= 1'b0;
            stg_full_q  <= 1'b0;
            stg_glyph_q <= '0;
            stg_attr_q  <= '0;
        end else begin
            ready_q     <= ready_d;
            font_en_q   <= font_en_d;
            font_addr_q <= font_addr_d;
            req_attr_q  <= req_attr_d;
            rdata_vld_q <= rdata_vld_d;
            stg_full_q  <= stg_full_d;
            stg_glyph_q <= stg_glyph_d;
            stg_attr_q  <= stg_attr_d;
        end
    end

    glyph_shifter #(
        .GLYPH_W (GLYPH_W),
        .COLOR_W (COLOR_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (load),
        .load_data (load_glyph),
        .load_attr (load_attr),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_color (pix_color),
        .pix_last  (pix_last),
        .empty     (sh_empty),
        .last_fire (sh_last_fire)
    );

endmodule

// File: tb/tb_glyph_pixel_serializer.sv
// Directed bench for glyph_pixel_serializer with a 1-cycle registered font ROM model (data = addr[7:0]).
module tb_glyph_pixel_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_code;
    logic [3:0]  char_row;
    logic [7:0]  char_attr;
    logic        font_en;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  pix_color;
    logic        pix_last;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    logic [7:0] rom_q;
    always_ff @(posedge clk) begin
        if (font_en) rom_q <= font_addr[7:0];
    end
    assign font_data = rom_q;

    glyph_pixel_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_code  (char_code),
        .char_row   (char_row),
        .char_attr  (char_attr),
        .font_en    (font_en),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_color  (pix_color),
        .pix_last   (pix_last)
    );

    typedef struct {
        logic [7:0]  code;
        logic [3:0]  row;
        logic [7:0]  attr;
        logic [31:0] colors;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns one cycle after it was accepted.
    task automatic issue(input logic [7:0] code, input logic [3:0] row, input logic [7:0] attr,
                         input string tag);
        int n = 0;
        char_valid = 1'b1;
        char_code  = code;
        char_row   = row;
        char_attr  = attr;
        while (!char_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req_ready"}, 32'(char_ready), 32'd1);
        tick();
        char_valid = 1'b0;
    endtask

    task automatic run_glyph(input logic [7:0] code, input logic [3:0] row, input logic [7:0] attr,
                             input logic [31:0] exp, input string tag);
        logic [31:0] got;
        logic [7:0]  lastm;
        int          vcnt;
        issue(code, row, attr, tag);
        check({tag, "_font_en"}, 32'(font_en), 32'd1);
        check({tag, "_font_addr"}, 32'(font_addr), 32'({code, row}));
        tick();
        check({tag, "_n2_en_valid"}, 32'({font_en, pix_valid}), 32'd0);
        tick();
        got   = '0;
        lastm = '0;
        vcnt  = 0;
        for (int p = 0; p < 8; p++) begin
            vcnt += int'(pix_valid);
            got   = {got[27:0], pix_color};
            lastm = {lastm[6:0], pix_last};
            tick();
        end
        check({tag, "_valid_cnt"}, 32'(vcnt), 32'd8);
        check({tag, "_colors"}, got, exp);
        check({tag, "_last"}, 32'(lastm), 32'h01);
        check({tag, "_valid_after"}, 32'(pix_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] vmask, lmask, rmask;
        logic [3:0]  lc[24];
        logic [31:0] g1, g2;
        logic [3:0]  hc[16];
        logic [15:0] hl;
        logic        pend, prev_stall, pv, pl;
        logic [3:0]  pc;
        int          acc, nhs, viol, seen;
        logic [3:0]  bp;

        vecs[0] = '{8'h41, 4'h5, 8'hA3, 32'h333A3A3A};
        vecs[1] = '{8'h12, 4'h4, 8'h5C, 32'hCC5CC5CC};
        vecs[2] = '{8'h7F, 4'hF, 8'hE1, 32'hEEEEEEEE};
        vecs[3] = '{8'h00, 4'h0, 8'h70, 32'h00000000};
        vecs[4] = '{8'h01, 4'h0, 8'h96, 32'h66696666};
        vecs[5] = '{8'hFF, 4'hA, 8'h2B, 32'h22222B2B};

        rst_n = 1'b0; flush = 1'b0; char_valid = 1'b0; pix_ready = 1'b1;
        char_code = '0; char_row = '0; char_attr = '0;
        tick(); tick();
        check("rst_outputs", 32'({char_ready, font_en, pix_valid, pix_last}), 32'd0);
        check("rst_addr_color", 32'({font_addr, pix_color}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready_low", 32'(char_ready), 32'd0);
        tick();
        check("rst_release_ready_high", 32'(char_ready), 32'd1);

        for (int i = 0; i < 6; i++)
            run_glyph(vecs[i].code, vecs[i].row, vecs[i].attr, vecs[i].colors, $sformatf("vec%0d", i));

        // Back-to-back requests with char_valid held.
        char_valid = 1'b1; char_code = 8'h12; char_row = 4'h4; char_attr = 8'h5C;
        acc = 0; vmask = '0; lmask = '0; rmask = '0;
        for (int c = 0; c < 24; c++) begin
            vmask[c] = pix_valid; lmask[c] = pix_last; rmask[c] = char_ready; lc[c] = pix_color;
            pend = char_valid && char_ready;
            tick();
            if (pend) begin
                acc++;
                if (acc == 1) begin
                    char_code = 8'h7F; char_row = 4'hF; char_attr = 8'hE1;
                end else begin
                    char_valid = 1'b0;
                end
            end
        end
        g1 = '0; g2 = '0;
        for (int p = 0; p < 8; p++) begin
            g1 = {g1[27:0], lc[3 + p]};
            g2 = {g2[27:0], lc[11 + p]};
        end
        check("b2b_accepts", 32'(acc), 32'd2);
        check("b2b_valid_mask", 32'(vmask), 32'h0007FFF8);
        check("b2b_last_mask", 32'(lmask), 32'h00040400);
        check("b2b_ready_mask", 32'(rmask), 32'h00FFF809);
        check("b2b_glyph1", g1, 32'hCC5CC5CC);
        check("b2b_glyph2", g2, 32'hEEEEEEEE);

        // Backpressure: pix_ready pattern 1,0,0,1 across two glyphs.
        bp = 4'b1001;
        char_valid = 1'b1; char_code = 8'h41; char_row = 4'h5; char_attr = 8'hA3;
        acc = 0; nhs = 0; viol = 0; prev_stall = 1'b0; hl = '0; pv = 1'b0; pc = '0; pl = 1'b0;
        for (int c = 0; c < 80; c++) begin
            pix_ready = bp[c % 4];
            if (prev_stall && (pix_valid !== pv || pix_color !== pc || pix_last !== pl)) viol++;
            if (pix_valid && pix_ready) begin
                if (nhs < 16) begin
                    hc[nhs] = pix_color;
                    hl[nhs] = pix_last;
                end
                nhs++;
            end
            prev_stall = pix_valid && !pix_ready;
            pv = pix_valid; pc = pix_color; pl = pix_last;
            pend = char_valid && char_ready;
            tick();
            if (pend) begin
                acc++;
                if (acc == 1) begin
                    char_code = 8'hFF; char_row = 4'hA; char_attr = 8'h2B;
                end else begin
                    char_valid = 1'b0;
                end
            end
        end
        pix_ready = 1'b1;
        g1 = '0; g2 = '0;
        for (int p = 0; p < 8; p++) begin
            g1 = {g1[27:0], hc[p]};
            g2 = {g2[27:0], hc[8 + p]};
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_handshakes", 32'(nhs), 32'd16);
        check("bp_stall_stable", 32'(viol), 32'd0);
        check("bp_glyph1", g1, 32'h333A3A3A);
        check("bp_glyph2", g2, 32'h22222B2B);
        check("bp_last_pos", 32'(hl), 32'h00008080);
        tick();

        // flush wins over a simultaneous request.
        char_valid = 1'b1; char_code = 8'h33; char_row = 4'h1; char_attr = 8'hFF; flush = 1'b1;
        #1;
        check("flush_blocks_ready", 32'(char_ready), 32'd0);
        tick();
        flush = 1'b0; char_valid = 1'b0;
        check("flush_no_accept", 32'(font_en), 32'd0);

        // flush while a fetch is in flight drops its data.
        issue(8'h20, 4'h0, 8'hF0, "flush_req");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            seen += int'(pix_valid);
            tick();
        end
        check("flush_no_pixels", 32'(seen), 32'd0);
        run_glyph(8'h01, 4'h0, 8'h96, 32'h66696666, "post_flush");

        // Reset in the middle of a glyph.
        issue(8'h7F, 4'hF, 8'hE1, "rst_req");
        tick(); tick();
        for (int p = 0; p < 4; p++) tick();
        check("rst_mid_pre_valid", 32'(pix_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_async_out", 32'({char_ready, font_en, pix_valid, pix_last, pix_color}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_ready", 32'(char_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            seen += int'(pix_valid);
            tick();
        end
        check("rst_mid_no_residual", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
